// File: rtl/rackbus_cin_gen.sv
// rackbus_cin_gen: per-SURF command-in serializer word generator.
// Each channel trains with TRAIN_PATTERN, idles at zeros, and sends NBEAT-beat
// commands MSB beat first. Optional macro RACKBUS_CIN_PARITY_EN appends one
// even-parity beat to every command.
module rackbus_cin_gen #(
  parameter int unsigned NSURF         = 7,
  parameter int unsigned DW            = 8,
  parameter int unsigned NBEAT         = 4,
  parameter logic [DW-1:0] TRAIN_PATTERN = DW'(8'b0110_1001),
  parameter int unsigned HOLDOFF       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSURF-1:0]         train_i,
  input  logic [NSURF*DW*NBEAT-1:0] cmd_dat_i,
  input  logic [NSURF-1:0]         cmd_valid_i,
  output logic [NSURF-1:0]         cmd_ready_o,
  output logic [NSURF*DW-1:0]      dat_o,
  output logic [2*NSURF-1:0]       state_o
);

  localparam int unsigned CW = DW * NBEAT;
  localparam int unsigned BW = $clog2(NBEAT + 1);
  localparam int unsigned HW = 8;
`ifdef RACKBUS_CIN_PARITY_EN
  localparam int unsigned LAST_BEAT = NBEAT;
`else
  localparam int unsigned LAST_BEAT = NBEAT - 1;
`endif

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  for (genvar g = 0; g < NSURF; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          pend_q, pend_d;
    logic          ready_c;
    logic          last_c;
    logic [CW-1:0] cmd_in_c;
    logic [CW-1:0] cmd_sh_c;
`ifdef RACKBUS_CIN_PARITY_EN
    logic          par_q, par_d;
`endif

    assign cmd_in_c = cmd_dat_i[g*CW +: CW];
    assign cmd_sh_c = cmd_q << DW;
    assign last_c   = (beat_q == BW'(LAST_BEAT));

    // Next-state, next output word and combinational ready for this channel.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      beat_d  = beat_q;
      cmd_d   = cmd_q;
      dat_d   = dat_q;
      pend_d  = pend_q;
      ready_c = 1'b0;
`ifdef RACKBUS_CIN_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
        ST_TRAIN: begin
          dat_d = TRAIN_PATTERN;
          if (train_i[g]) begin
            hold_d = '0;
          end else if (hold_q >= HW'(HOLDOFF)) begin
            hold_d  = '0;
            state_d = ST_IDLE;
            dat_d   = '0;
          end else if (hold_q != {HW{1'b1}}) begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_IDLE: begin
          dat_d   = '0;
          ready_c = ~train_i[g];
          if (train_i[g]) begin
            state_d = ST_TRAIN;
            dat_d   = TRAIN_PATTERN;
          end
        end
        ST_SEND: begin
          // A training request mid-command is remembered until the final beat.
          if (train_i[g]) pend_d = 1'b1;
          if (!last_c) begin
            beat_d = beat_q + BW'(1);
            cmd_d  = cmd_sh_c;
            dat_d  = cmd_sh_c[CW-1 -: DW];
`ifdef RACKBUS_CIN_PARITY_EN
            if (beat_q == BW'(NBEAT - 1)) dat_d = DW'(par_q);
`endif
          end else begin
            ready_c = ~(train_i[g] | pend_q);
            pend_d  = 1'b0;
            if (train_i[g] | pend_q) begin
              state_d = ST_TRAIN;
              dat_d   = TRAIN_PATTERN;
            end else begin
              state_d = ST_IDLE;
              dat_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_TRAIN;
          dat_d   = TRAIN_PATTERN;
        end
      endcase
      // Acceptance overrides the idle/return path and starts beat 0 next cycle.
      if (ready_c && cmd_valid_i[g]) begin
        state_d = ST_SEND;
        beat_d  = '0;
        cmd_d   = cmd_in_c;
        dat_d   = cmd_in_c[CW-1 -: DW];
        pend_d  = 1'b0;
`ifdef RACKBUS_CIN_PARITY_EN
        par_d   = ^cmd_in_c;
`endif
      end
    end

    // Channel state and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_TRAIN;
        hold_q  <= '0;
        beat_q  <= '0;
        cmd_q   <= '0;
        dat_q   <= TRAIN_PATTERN;
        pend_q  <= 1'b0;
`ifdef RACKBUS_CIN_PARITY_EN
        par_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        beat_q  <= beat_d;
        cmd_q   <= cmd_d;
        dat_q   <= dat_d;
        pend_q  <= pend_d;
`ifdef RACKBUS_CIN_PARITY_EN
        par_q   <= par_d;
`endif
      end
    end

    assign cmd_ready_o[g]      = ready_c;
    assign dat_o[g*DW +: DW]   = dat_q;
    assign state_o[g*2 +: 2]   = state_q;
  end

endmodule

// File: doc/rackbus_cin_gen.md
RACKBUS_CIN_GEN -- requirements
Module: rackbus_cin_gen

Interface
REQ-001 SHALL have parameter NSURF, default 7, number of independent SURF command-in (CIN) channels.
REQ-002 SHALL have parameter DW, default 8, bits per channel per clock presented to the serializer.
REQ-003 SHALL have parameter NBEAT, default 4, beats per command; command width CW = DW*NBEAT.
REQ-004 SHALL have parameter TRAIN_PATTERN, DW bits, default 8'b0110_1001, the alignment word.
REQ-005 SHALL have parameter HOLDOFF, default 16, range 1-255, consecutive cycles train_i must be low before leaving training.
REQ-006 SHALL have port clk, input, 1, sysclk domain; the only clock.
REQ-007 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port train_i, input, NSURF, per-channel training request.
REQ-009 SHALL have port cmd_dat_i, input, NSURF*CW; channel i occupies bits [i*CW +: CW].
REQ-010 SHALL have port cmd_valid_i, input, NSURF, per-channel command valid.
REQ-011 SHALL have port cmd_ready_o, output, NSURF, per-channel command ready.
REQ-012 SHALL have port dat_o, output, NSURF*DW, registered serializer parallel data; channel i at [i*DW +: DW].
REQ-013 SHALL have port state_o, output, 2*NSURF, per-channel state code: TRAIN=0, IDLE=1, SEND=2.

Function
REQ-014 Each channel SHALL run an independent FSM with states TRAIN, IDLE, SEND; no cross-channel coupling.
REQ-015 In TRAIN, dat_o SHALL equal TRAIN_PATTERN every cycle and cmd_ready_o SHALL be 0.
REQ-016 In TRAIN, an 8-bit holdoff counter SHALL increment each cycle train_i is 0, clear to 0 on any cycle train_i is 1, and saturate.
REQ-017 TRAIN SHALL exit to IDLE on the cycle after the counter reaches HOLDOFF; the counter SHALL clear on exit.
REQ-018 In IDLE, dat_o SHALL be all-zeros and cmd_ready_o SHALL be 1 unless train_i is 1.
REQ-019 In IDLE, train_i=1 SHALL move to TRAIN next cycle; train_i takes priority over a simultaneous cmd_valid_i (no accept).
REQ-020 A command SHALL be accepted on a cycle where cmd_valid_i and cmd_ready_o are both 1; the FSM enters SEND next cycle.
REQ-021 Latency: word accepted at cycle N SHALL appear as beat 0 (bits [CW-1 -: DW], MSB first) on dat_o at N+1, beat k at N+1+k.
REQ-022 cmd_ready_o SHALL be 1 in SEND only on the final beat cycle; acceptance there SHALL start the next command with zero idle beats between.
REQ-023 With no acceptance on the final beat, the FSM SHALL return to IDLE (zeros) next cycle.
REQ-024 train_i asserted during SEND SHALL NOT truncate the command; the FSM SHALL go to TRAIN after the final beat and SHALL deassert cmd_ready_o on that beat.
REQ-025 The beat counter SHALL be clog2(NBEAT+1) bits wide and wrap to 0 on each new command.

Reset
REQ-026 While rst_n=0 at a clk edge, all channels SHALL enter TRAIN, holdoff and beat counters SHALL clear, cmd_ready_o SHALL be 0, and dat_o SHALL be TRAIN_PATTERN on every channel the following cycle.
REQ-027 Reset mid-SEND SHALL abandon the command immediately; no further beats of it SHALL appear.

Configuration
REQ-028 Macro RACKBUS_CIN_PARITY_EN: when defined, each command SHALL be followed by one extra beat {DW-1 zeros, even parity (XOR) of all CW bits}, making SEND NBEAT+1 beats, with REQ-022 ready applying to the parity beat; when undefined, SEND SHALL be exactly NBEAT beats with no parity logic.

Verification
REQ-029 Reset release with train_i=0, HOLDOFF=16 -> dat_o=TRAIN_PATTERN for reset cycle +16, state IDLE and cmd_ready_o=1 on the following cycle, dat_o=0.
REQ-030 IDLE, cmd 32'hDEADBEEF valid one cycle (NBEAT=4, DW=8) -> dat_o DE, AD, BE, EF on next 4 cycles, then 00; with RACKBUS_CIN_PARITY_EN, 5th beat 8'h00 (even count of ones in DEADBEEF: 24).
REQ-031 Back-to-back: valid held with 32'h01020304 then 32'hA0B0C0D0 -> beats 01,02,03,04,A0,B0,C0,D0 contiguous, no zero gap.
REQ-032 train_i pulsed on beat 1 of a command -> all 4 beats sent, then TRAIN_PATTERN; train_i low 16 cycles returns IDLE.
REQ-033 NSURF=7, channel 3 in TRAIN while channel 0 sends 32'h11223344 -> channel 0 output unaffected, channel 3 holds TRAIN_PATTERN.
REQ-034 rst_n low on beat 2 -> next cycle TRAIN_PATTERN, cmd_ready_o=0, remaining beats never emitted.
